// File: rtl/display_scan_sched_if.sv
// Message-source handshake bundle for display_scan_sched.
// The master side (message source) raises msg_req with msg_data and holds
// it until msg_ack; the slave side (scan scheduler) returns a one-cycle ack.
interface display_scan_sched_if;
    logic        msg_req;
    logic [31:0] msg_data;
    logic        msg_ack;

    modport master (
        output msg_req,
        output msg_data,
        input  msg_ack
    );

    modport slave (
        input  msg_req,
        input  msg_data,
        output msg_ack
    );
endinterface

// File: rtl/display_scan_sched.sv
// display_scan_sched: time-multiplexed scan controller and source arbiter
// for a 4-digit common-anode 7-segment display. The temperature source owns
// the display by default; a message source borrows it for HOLD_FRAMES frames
// through a req/ack handshake. Ownership only changes at frame boundaries.
// Optional feature macro: DISP_LZ_BLANK_EN (blank digit3 when dec is 0 while
// the temperature source owns the display).
module display_scan_sched #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 est,
    input  logic [3:0]                 uni,
    input  logic [3:0]                 dec,
    display_scan_sched_if.slave        bus,
    output logic                       owner,
    output logic [3:0]                 anodo,
    output logic [7:0]                 catodo
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [SC_W-1:0] SC_BLANK = SC_W'(BLANK_CYC);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(HOLD_FRAMES - 1);

    typedef enum logic {
        ST_TEMP = 1'b0,
        ST_MSG  = 1'b1
    } state_t;

    logic [SC_W-1:0] r_sc;
    logic [1:0]      r_dg;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [FC_W-1:0] r_fc;
    logic [FC_W-1:0] w_fc_nxt;
    logic [31:0]     r_msg;
    logic            r_ack;
    logic [3:0]      r_anodo;
    logic [7:0]      r_catodo;
    logic            w_frame_end;
    logic            w_grant;
    logic [3:0]      w_anodo_nxt;
    logic [7:0]      w_catodo_nxt;
    logic [7:0]      w_dec_glyph;

    // BCD digit to active-low segments {dp,g,f,e,d,c,b,a}; non-BCD shows E.
    function automatic logic [7:0] f_bcd_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'h86;
        endcase
        return g;
    endfunction

    // Status code to letter: normal 0, alert A, check C, danger P.
    function automatic logic [7:0] f_status_glyph(input logic [1:0] s);
        logic [7:0] g;
        case (s)
            2'b00:   g = 8'hC0;
            2'b01:   g = 8'h88;
            2'b10:   g = 8'hC6;
            default: g = 8'h8C;
        endcase
        return g;
    endfunction

    assign w_frame_end = (r_sc == SC_LAST) && (r_dg == 2'd3);
    assign owner       = (r_state == ST_MSG);
    assign bus.msg_ack = r_ack;
    assign anodo       = r_anodo;
    assign catodo      = r_catodo;

    // Slot counter and digit index; the digit advances when the slot wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sc <= '0;
            r_dg <= 2'd0;
        end else if (r_sc == SC_LAST) begin
            r_sc <= '0;
            r_dg <= r_dg + 2'd1;
        end else begin
            r_sc <= r_sc + 1'b1;
        end
    end

    // Ownership next-state: grants and returns are evaluated only at frame ends,
    // so the frame after a return is always a full temperature frame.
    always_comb begin
        w_state_nxt = r_state;
        w_fc_nxt    = r_fc;
        w_grant     = 1'b0;
        case (r_state)
            ST_TEMP: begin
                if (w_frame_end && bus.msg_req) begin
                    w_grant     = 1'b1;
                    w_fc_nxt    = '0;
                    w_state_nxt = ST_MSG;
                end
            end
            ST_MSG: begin
                if (w_frame_end) begin
                    if (r_fc == FC_LAST) begin
                        w_state_nxt = ST_TEMP;
                    end else begin
                        w_fc_nxt = r_fc + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_TEMP;
        endcase
    end

    // Ownership state, frame counter, grant pulse and message capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_TEMP;
            r_fc    <= '0;
            r_ack   <= 1'b0;
            r_msg   <= 32'hFFFF_FFFF;
        end else begin
            r_state <= w_state_nxt;
            r_fc    <= w_fc_nxt;
            r_ack   <= w_grant;
            if (w_grant) begin
                r_msg <= bus.msg_data;
            end
        end
    end

    // Digit3 glyph, optionally blanked when the tens digit is a leading zero.
    always_comb begin
        w_dec_glyph = f_bcd_glyph(dec);
`ifdef DISP_LZ_BLANK_EN
        if (dec == 4'd0) begin
            w_dec_glyph = 8'hFF;
        end
`endif
    end

    // Anode and segment selection for the current slot and owner.
    always_comb begin
        w_anodo_nxt  = 4'b1111;
        w_catodo_nxt = 8'hFF;
        if (r_sc >= SC_BLANK) begin
            w_anodo_nxt = ~(4'b0001 << r_dg);
        end
        if (r_state == ST_MSG) begin
            w_catodo_nxt = r_msg[{r_dg, 3'b000} +: 8];
        end else begin
            case (r_dg)
                2'd0:    w_catodo_nxt = f_status_glyph(est);
                2'd1:    w_catodo_nxt = 8'hBF;
                2'd2:    w_catodo_nxt = f_bcd_glyph(uni);
                default: w_catodo_nxt = w_dec_glyph;
            endcase
        end
    end

    // Registered display outputs, one cycle behind the scan position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_anodo  <= 4'b1111;
            r_catodo <= 8'hFF;
        end else begin
            r_anodo  <= w_anodo_nxt;
            r_catodo <= w_catodo_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_sched.sv
// Directed testbench for display_scan_sched with SCAN_DIV=8, BLANK_CYC=2,
// HOLD_FRAMES=3 (8-cycle slots, 32-cycle frames, 96-cycle message hold).
module tb_display_scan_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] est;
    logic [3:0] uni;
    logic [3:0] dec;
    logic       owner;
    logic [3:0] anodo;
    logic [7:0] catodo;

    int n;
    int checks = 0;
    int passed = 0;

    localparam logic [31:0] MSG_W  = 32'h8CC0F9A4;
    localparam logic [31:0] TEMP_A = 32'hA4F8BF88;

    display_scan_sched_if u_if();

    display_scan_sched #(
        .SCAN_DIV   (8),
        .BLANK_CYC  (2),
        .HOLD_FRAMES(3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .est   (est),
        .uni   (uni),
        .dec   (dec),
        .bus   (u_if),
        .owner (owner),
        .anodo (anodo),
        .catodo(catodo)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after edge n the outputs show position n-1.
    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    function automatic logic [3:0] exp_an(input int pos);
        int s;
        int d;
        s = pos % 8;
        d = (pos / 8) % 4;
        if (s < 2) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int pos);
        int d;
        d = (pos / 8) % 4;
        return w[d*8 +: 8];
    endfunction

    function automatic bit lit(input int pos);
        return (pos % 8) >= 2;
    endfunction

    task automatic test_reset();
        int pos;
        est = 2'b01; uni = 4'd7; dec = 4'd2;
        u_if.msg_req = 1'b0; u_if.msg_data = 32'h0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (anodo !== 4'b1111) $display("FAIL reset_anodo got %h want f", anodo); else passed++;
        checks++; if (catodo !== 8'hFF) $display("FAIL reset_catodo got %h want ff", catodo); else passed++;
        checks++; if (owner !== 1'b0) $display("FAIL reset_owner got %b want 0", owner); else passed++;
        checks++; if (u_if.msg_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", u_if.msg_ack); else passed++;
        rst = 1'b1;
        while (n < 32) begin
            @(negedge clk);
            pos = n - 1;
            checks++; if (anodo !== exp_an(pos)) $display("FAIL scan_anodo n=%0d got %h want %h", n, anodo, exp_an(pos)); else passed++;
            if (lit(pos)) begin
                checks++; if (catodo !== exp_byte(TEMP_A, pos)) $display("FAIL scan_catodo n=%0d got %h want %h", n, catodo, exp_byte(TEMP_A, pos)); else passed++;
            end
        end
    endtask

    task automatic test_grant();
        int pos;
        int own_cnt = 0;
        logic [31:0] w;
        u_if.msg_data = MSG_W;
        while (n < 200) begin
            @(negedge clk);
            pos = n - 1;
            w = (pos >= 64 && pos <= 159) ? MSG_W : TEMP_A;
            if (owner === 1'b1) own_cnt++;
            checks++; if (u_if.msg_ack !== (n == 64)) $display("FAIL grant_ack n=%0d got %b want %b", n, u_if.msg_ack, (n == 64)); else passed++;
            checks++; if (owner !== (n >= 64 && n <= 159)) $display("FAIL grant_owner n=%0d got %b want %b", n, owner, (n >= 64 && n <= 159)); else passed++;
            checks++; if (anodo !== exp_an(pos)) $display("FAIL grant_anodo n=%0d got %h want %h", n, anodo, exp_an(pos)); else passed++;
            if (lit(pos)) begin
                checks++; if (catodo !== exp_byte(w, pos)) $display("FAIL grant_catodo n=%0d got %h want %h", n, catodo, exp_byte(w, pos)); else passed++;
            end
            if (n == 40) u_if.msg_req = 1'b1;
            if (n == 64) u_if.msg_req = 1'b0;
        end
        checks++; if (own_cnt != 96) $display("FAIL grant_owner_cycles got %0d want 96", own_cnt); else passed++;
    endtask

    task automatic test_fairness();
        int pos;
        int gap = 0;
        int acks = 0;
        bit in_msg;
        u_if.msg_req = 1'b1;
        while (n < 360) begin
            @(negedge clk);
            pos = n - 1;
            in_msg = (pos >= 224 && pos <= 319) || (pos >= 352);
            if (u_if.msg_ack === 1'b1) acks++;
            if (n >= 320 && n <= 351 && owner === 1'b0) gap++;
            checks++; if (u_if.msg_ack !== (n == 224 || n == 352)) $display("FAIL fair_ack n=%0d got %b", n, u_if.msg_ack); else passed++;
            checks++; if (owner !== ((n >= 224 && n <= 319) || n >= 352)) $display("FAIL fair_owner n=%0d got %b", n, owner); else passed++;
            if (lit(pos)) begin
                checks++; if (catodo !== exp_byte(in_msg ? MSG_W : TEMP_A, pos)) $display("FAIL fair_catodo n=%0d got %h want %h", n, catodo, exp_byte(in_msg ? MSG_W : TEMP_A, pos)); else passed++;
            end
        end
        u_if.msg_req = 1'b0;
        checks++; if (gap != 32) $display("FAIL fair_temp_gap got %0d want 32", gap); else passed++;
        checks++; if (acks != 2) $display("FAIL fair_ack_count got %0d want 2", acks); else passed++;
    endtask

    task automatic test_reset_mid_msg();
        int pos;
        checks++; if (owner !== 1'b1) $display("FAIL rstmid_pre_owner got %b want 1", owner); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (anodo !== 4'b1111) $display("FAIL rstmid_anodo got %h want f", anodo); else passed++;
        checks++; if (catodo !== 8'hFF) $display("FAIL rstmid_catodo got %h want ff", catodo); else passed++;
        checks++; if (owner !== 1'b0) $display("FAIL rstmid_owner got %b want 0", owner); else passed++;
        checks++; if (u_if.msg_ack !== 1'b0) $display("FAIL rstmid_ack got %b want 0", u_if.msg_ack); else passed++;
        repeat (3) begin
            @(negedge clk);
            checks++; if (anodo !== 4'b1111 || owner !== 1'b0) $display("FAIL rstmid_hold got an=%h own=%b want f/0", anodo, owner); else passed++;
        end
        rst = 1'b1;
        while (n < 32) begin
            @(negedge clk);
            pos = n - 1;
            checks++; if (anodo !== exp_an(pos)) $display("FAIL resume_anodo n=%0d got %h want %h", n, anodo, exp_an(pos)); else passed++;
            checks++; if (owner !== 1'b0 || u_if.msg_ack !== 1'b0) $display("FAIL resume_owner_ack n=%0d got %b/%b want 0/0", n, owner, u_if.msg_ack); else passed++;
            if (lit(pos)) begin
                checks++; if (catodo !== exp_byte(TEMP_A, pos)) $display("FAIL resume_catodo n=%0d got %h want %h", n, catodo, exp_byte(TEMP_A, pos)); else passed++;
            end
        end
    endtask

    task automatic test_invalid_bcd();
        int pos;
        logic [31:0] w;
        est = 2'b11; uni = 4'd12; dec = 4'd2;
        w = 32'hA486BF8C;
        while (n < 96) begin
            @(negedge clk);
            if (n == 64) begin
                est = 2'b10; uni = 4'd9; dec = 4'd15;
            end
            pos = n - 1;
            if (lit(pos)) begin
                checks++; if (catodo !== exp_byte(w, pos)) $display("FAIL invalid_catodo n=%0d got %h want %h", n, catodo, exp_byte(w, pos)); else passed++;
            end
            if (n == 64) w = 32'h8690BFC6;
        end
    endtask

    task automatic test_lz_blank();
        int pos;
        logic [31:0] w;
        est = 2'b00; uni = 4'd5; dec = 4'd0;
`ifdef DISP_LZ_BLANK_EN
        w = 32'hFF92BFC0;
`else
        w = 32'hC092BFC0;
`endif
        while (n < 128) begin
            @(negedge clk);
            pos = n - 1;
            checks++; if (anodo !== exp_an(pos)) $display("FAIL lz_anodo n=%0d got %h want %h", n, anodo, exp_an(pos)); else passed++;
            if (lit(pos)) begin
                checks++; if (catodo !== exp_byte(w, pos)) $display("FAIL lz_catodo n=%0d got %h want %h", n, catodo, exp_byte(w, pos)); else passed++;
            end
        end
    endtask

    task automatic test_withdraw();
        while (n < 200) begin
            @(negedge clk);
            checks++; if (u_if.msg_ack !== 1'b0 || owner !== 1'b0) $display("FAIL withdraw n=%0d got ack=%b own=%b want 0/0", n, u_if.msg_ack, owner); else passed++;
            if (n == 130) u_if.msg_req = 1'b1;
            if (n == 140) u_if.msg_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_fairness();
        test_reset_mid_msg();
        test_invalid_bcd();
        test_lz_blank();
        test_withdraw();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_sched.md
# display_scan_sched

Time-multiplexed scan controller and display arbiter for the board's 4-digit, 7-segment, common-anode display. It drives the anodes and cathodes from one of two sources. The default source is the temperature monitor, which supplies the status code, units and tens. The other is a message source that borrows the whole display for a fixed number of scan frames through a req/ack handshake. A programmable digit period with leading blanking suppresses ghosting between digits.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 500: cycles at the start of each slot during which all anodes are off.
- `HOLD_FRAMES`, 250: full scan frames (4 slots each) a granted message stays on the display.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `est` in 2: system status code (00 normal, 01 alert, 10 check, 11 danger).
- `uni` in 4: temperature units, BCD.
- `dec` in 4: temperature tens, BCD.
- `msg_req` in 1: message source requests the display; held high until `msg_ack`.
- `msg_data` in 32: raw active-low segment patterns; [7:0] digit0 (rightmost) … [31:24] digit3.
- `msg_ack` out 1: one-cycle grant pulse; `msg_data` is captured on the same edge.
- `owner` out 1: 0 = temperature source, 1 = message source.
- `anodo` out 4: active-low digit enables; bit0 = rightmost digit.
- `catodo` out 8: active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- Scan counter `sc` counts 0..`SCAN_DIV`-1. When `sc` wraps, digit index `dg` increments modulo 4. A frame boundary is the cycle with `sc`=`SCAN_DIV`-1 and `dg`=3.
- Anode output:
  - 1111 while `sc` < `BLANK_CYC`.
  - Otherwise the one-cold pattern for `dg`: 1110, 1101, 1011, 0111.
- Temperature content by digit:
  - digit0: `est` code. 00 → `0` (11000000), 01 → `A` (10001000), 10 → `C` (11000110), 11 → `P` (10001100).
  - digit1: dash (10111111).
  - digit2: `uni`.
  - digit3: `dec`.
  - Digit glyphs 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). Any BCD value > 9 displays `E` (10000110).
- Message content: digit n shows the captured `msg_data` byte n unmodified.
- Ownership FSM has two states.
  - TEMP. At a frame boundary with `msg_req`=1: capture `msg_data`, pulse `msg_ack`, clear the frame counter, and go to MSG. All other requests wait.
  - MSG. The frame counter increments at each frame boundary. At the boundary where it reaches `HOLD_FRAMES`-1, return to TEMP.
  - `msg_req` has no effect while in MSG.
  - After MSG, at least one full temperature frame is shown before the next grant. A request pending at the return boundary is granted at the following boundary.
- Source switches happen only at frame boundaries, so no frame mixes the two sources.
- `est`, `uni` and `dec` are sampled live. They are assumed synchronous to `clk`.

## Timing
- Reset values: `anodo`=1111, `catodo`=11111111, `msg_ack`=0, `owner`=0. Internally `sc`=0, `dg`=0, state TEMP, frame counter 0, message register FF…FF.
- `anodo` and `catodo` are registered, one cycle behind (`sc`, `dg`, state).
- `msg_ack` is high for exactly the cycle after the grant boundary. `owner` rises on that same cycle. The first message pixels appear one cycle later, at the start of digit0's slot, after blanking.
- Frame length is 4·`SCAN_DIV` cycles. A message is displayed for `HOLD_FRAMES`·4·`SCAN_DIV` cycles.
- Asserting `rst` mid-message asynchronously returns all outputs and state to reset values. The captured message is discarded and no `msg_ack` is issued. After reset release, scanning restarts at digit0 with `sc`=0.
- A `msg_req` drop before ack withdraws the request cleanly.

## Configuration
- `DISP_LZ_BLANK_EN` defined: in TEMP, when `dec`=0, digit3 outputs 11111111 (leading-zero blanking). Its anode still scans normally.
- Not defined: digit3 always shows the `dec` glyph, including `0`.
- Message content is never affected by this macro.

## Test plan
Bench parameters for all scenarios: `SCAN_DIV`=8, `BLANK_CYC`=2, `HOLD_FRAMES`=3.

- **Reset and scan.** Release `rst` with `est`=01, `uni`=7, `dec`=2. Expect:
  - each 8-cycle slot shows `anodo`=1111 for 2 cycles, then 1110/1101/1011/0111 in sequence;
  - `catodo` = 88, BF, F8, A4.
- **Grant.** Raise `msg_req` mid-frame with `msg_data`=0x8C_C0_F9_A4. Expect:
  - `msg_ack` pulses once, only after the frame boundary;
  - the next frame shows A4, F9, C0, 8C;
  - `owner`=1 for exactly 96 cycles.
- **Fairness.** Hold `msg_req` high continuously. Expect:
  - after 3 message frames, exactly one temperature frame (32 cycles);
  - then a second `msg_ack`.
- **Reset mid-message.** Pulse `rst` low for 3 cycles during MSG. Expect:
  - `anodo`=1111, `catodo`=FF and `owner`=0 immediately;
  - the temperature display resumes at digit0.
- **Invalid BCD.** Drive `uni`=12. Expect digit2 shows 86.
- **Leading-zero blanking.** Drive `dec`=0 and `uni`=5. Expect digit3:
  - FF with `DISP_LZ_BLANK_EN` defined;
  - C0 without it.
